data_memory_arbiter: RTL

Shares the single-port data RAM between the pipeline MEM stage (CPU side) and an external word-transfer requester (DMA side, e.g. a port loader or debug engine).
- The CPU has priority.
- The DMA side gets opportunistic slots whenever the MEM stage is idle.
- A starvation counter forces a bounded DMA burst by stalling the pipeline through cpu_stall, which feeds the hazard unit's PC/IF-ID write-block path.
- Address translation (base offset, byte-to-word shift) stays upstream. Both sides present word addresses.

---
 rtl/data_memory_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - single-port data RAM arbiter: CPU priority, opportunistic DMA
// slots, and starvation-forced DMA windows that stall the pipeline.
module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_mem_read,
  input  logic                  cpu_mem_write,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_granted,
  output logic [15:0]           starve_events,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_mem_write,
  output logic                  ram_mem_read,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic {S_CPU = 1'b0, S_DMA = 1'b1} state_t;

  localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT - 1);
  localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] burst_cnt;
  logic       cpu_busy;
  logic       cpu_sel;

  assign cpu_busy = cpu_mem_read | cpu_mem_write;
  assign cpu_sel  = (state == S_CPU) & cpu_busy;

  // Stall and grant come from the state register only, so the hazard unit sees no input path.
  assign cpu_stall   = (state == S_DMA);
  assign dma_granted = (state == S_DMA);
  assign dma_ack     = dma_req & ((state == S_DMA) | ~cpu_busy);

  assign cpu_rdata = ram_rdata;
  assign dma_rdata = ram_rdata;

  always_comb begin
    ram_addr      = '0;
    ram_wdata     = '0;
    ram_mem_write = 1'b0;
    ram_mem_read  = 1'b0;
    if (cpu_sel) begin
      ram_addr      = cpu_addr;
      ram_wdata     = cpu_wdata;
      ram_mem_write = cpu_mem_write;
      ram_mem_read  = cpu_mem_read;
    end else if (dma_ack) begin
      ram_addr      = dma_addr;
      ram_wdata     = dma_wdata;
      ram_mem_write = dma_we;
      ram_mem_read  = ~dma_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_CPU;
      wait_cnt      <= '0;
      burst_cnt     <= '0;
      starve_events <= '0;
    end else begin
      case (state)
        S_CPU: begin
          if (dma_req && !dma_ack) begin
            if (wait_cnt == WAIT_LAST) begin
              state     <= S_DMA;
              wait_cnt  <= '0;
              burst_cnt <= '0;
              if (starve_events != 16'hFFFF) starve_events <= starve_events + 16'd1;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end else begin
            wait_cnt <= '0;
          end
        end
        S_DMA: begin
          if (!dma_req || burst_cnt == BURST_LAST) begin
            state     <= S_CPU;
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end
        default: state <= S_CPU;
      endcase
    end
  end

endmodule
